sram_test_reporter: RTL and testbench



---
 rtl/sram_test_reporter_pkg.sv | 31 +++
 rtl/hex_ascii.sv | 14 +
 rtl/sram_test_reporter.sv | 191 +++++++++++++++++++
 tb/tb_sram_test_reporter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_reporter_pkg.sv
// Shared constants for the SRAM test reporter: ASCII codes, FSM states and
// message-length helpers derived from the data/counter widths.
package sram_test_reporter_pkg;

  localparam logic [7:0] CHAR_P  = 8'h50;
  localparam logic [7:0] CHAR_F  = 8'h46;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_A  = 8'h41;

  localparam int IDX_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_PASS,
    ST_SEND_FAIL
  } state_e;

  // "P " + count digits + CR LF
  function automatic int pass_msg_len(input int count_bits);
    return 4 + count_bits / 4;
  endfunction

  // "F " + state + " " + read digits + " " + expected digits + CR LF
  function automatic int fail_msg_len(input int data_bits);
    return 7 + 2 * (data_bits / 4);
  endfunction

endpackage

// File: rtl/hex_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex character.
module hex_ascii
  import sram_test_reporter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = CHAR_0 + {4'd0, nibble};
    else                ascii = CHAR_A + {4'd0, nibble} - 8'd10;
  end

endmodule

// File: rtl/sram_test_reporter.sv
// Turns SRAM tester pass/fail events into ASCII report lines on a
// valid/ready byte stream and keeps a wrapping count of completed passes.
module sram_test_reporter
  import sram_test_reporter_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  test_done,
  input  logic                  test_pass,
  input  logic [2:0]            pattern_state,
  input  logic [DATA_BITS-1:0]  prev_read_data,
  input  logic [DATA_BITS-1:0]  prev_expected_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [COUNT_BITS-1:0] pass_count,
  output logic                  failed
);

  localparam int DATA_DIGITS  = DATA_BITS / 4;
  localparam int COUNT_DIGITS = COUNT_BITS / 4;

  localparam logic [IDX_BITS-1:0] PASS_LAST = IDX_BITS'(pass_msg_len(COUNT_BITS) - 1);
  localparam logic [IDX_BITS-1:0] FAIL_LAST = IDX_BITS'(fail_msg_len(DATA_BITS) - 1);
  localparam logic [IDX_BITS-1:0] P_CR      = IDX_BITS'(2 + COUNT_DIGITS);
  localparam logic [IDX_BITS-1:0] F_STATE   = IDX_BITS'(2);
  localparam logic [IDX_BITS-1:0] F_SP1     = IDX_BITS'(3);
  localparam logic [IDX_BITS-1:0] F_SP2     = IDX_BITS'(4 + DATA_DIGITS);
  localparam logic [IDX_BITS-1:0] F_CR      = IDX_BITS'(5 + 2 * DATA_DIGITS);

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic                  test_done_q;
  logic                  failed_q, failed_d;
  logic                  pass_pend_q, pass_pend_d;
  logic                  fail_pend_q, fail_pend_d;
  logic [COUNT_BITS-1:0] pass_count_q, pass_count_d;
  logic [COUNT_BITS-1:0] count_snap_q, count_snap_d;
  logic [2:0]            state_snap_q, state_snap_d;
  logic [DATA_BITS-1:0]  read_snap_q, read_snap_d;
  logic [DATA_BITS-1:0]  exp_snap_q, exp_snap_d;

  logic                  pass_ev, fail_ev, start_pass, start_fail;
  logic [IDX_BITS-1:0]   digit_pos;
  logic [COUNT_BITS-1:0] count_shift;
  logic [DATA_BITS-1:0]  data_shift;
  logic [3:0]            nibble;
  logic [7:0]            hex_char;
  logic [7:0]            byte_sel;

  // Events; a start clears its pending flag but a same-edge event re-arms it.
  always_comb begin
    pass_ev      = test_done & ~test_done_q & ~failed_q;
    fail_ev      = ~test_pass & ~failed_q;
    failed_d     = failed_q | fail_ev;
    pass_count_d = pass_count_q + COUNT_BITS'(pass_ev);
    pass_pend_d  = (pass_pend_q & ~start_pass) | pass_ev;
    fail_pend_d  = (fail_pend_q & ~start_fail) | fail_ev;
    state_snap_d = state_snap_q;
    read_snap_d  = read_snap_q;
    exp_snap_d   = exp_snap_q;
    if (fail_ev) begin
      state_snap_d = pattern_state;
      read_snap_d  = prev_read_data;
      exp_snap_d   = prev_expected_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_snap_d = count_snap_q;
    start_pass   = 1'b0;
    start_fail   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fail_pend_q) begin
          state_d    = ST_SEND_FAIL;
          idx_d      = '0;
          start_fail = 1'b1;
        end else if (pass_pend_q) begin
          state_d      = ST_SEND_PASS;
          idx_d        = '0;
          start_pass   = 1'b1;
          count_snap_d = pass_count_q;
        end
      end
      ST_SEND_PASS, ST_SEND_FAIL: begin
        if (tx_ready) begin
          if (idx_q == ((state_q == ST_SEND_FAIL) ? FAIL_LAST : PASS_LAST)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pick the nibble for the current digit position; digit_pos counts down to 0 at the LSB.
  always_comb begin
    digit_pos   = '0;
    count_shift = '0;
    data_shift  = '0;
    nibble      = '0;
    if (state_q == ST_SEND_PASS) begin
      digit_pos   = P_CR - IDX_BITS'(1) - idx_q;
      count_shift = count_snap_q >> {digit_pos, 2'b00};
      nibble      = count_shift[3:0];
    end else if (state_q == ST_SEND_FAIL) begin
      if (idx_q == F_STATE) begin
        nibble = {1'b0, state_snap_q};
      end else if (idx_q < F_SP2) begin
        digit_pos  = F_SP2 - IDX_BITS'(1) - idx_q;
        data_shift = read_snap_q >> {digit_pos, 2'b00};
        nibble     = data_shift[3:0];
      end else begin
        digit_pos  = F_CR - IDX_BITS'(1) - idx_q;
        data_shift = exp_snap_q >> {digit_pos, 2'b00};
        nibble     = data_shift[3:0];
      end
    end
  end

  hex_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    byte_sel = 8'h00;
    case (state_q)
      ST_SEND_PASS: begin
        if      (idx_q == '0)             byte_sel = CHAR_P;
        else if (idx_q == IDX_BITS'(1))   byte_sel = CHAR_SP;
        else if (idx_q < P_CR)            byte_sel = hex_char;
        else if (idx_q == P_CR)           byte_sel = CHAR_CR;
        else                              byte_sel = CHAR_LF;
      end
      ST_SEND_FAIL: begin
        if      (idx_q == '0)             byte_sel = CHAR_F;
        else if (idx_q == IDX_BITS'(1))   byte_sel = CHAR_SP;
        else if (idx_q == F_SP1)          byte_sel = CHAR_SP;
        else if (idx_q == F_SP2)          byte_sel = CHAR_SP;
        else if (idx_q < F_CR)            byte_sel = hex_char;
        else if (idx_q == F_CR)           byte_sel = CHAR_CR;
        else                              byte_sel = CHAR_LF;
      end
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      test_done_q  <= 1'b0;
      failed_q     <= 1'b0;
      pass_pend_q  <= 1'b0;
      fail_pend_q  <= 1'b0;
      pass_count_q <= '0;
      count_snap_q <= '0;
      state_snap_q <= '0;
      read_snap_q  <= '0;
      exp_snap_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      test_done_q  <= test_done;
      failed_q     <= failed_d;
      pass_pend_q  <= pass_pend_d;
      fail_pend_q  <= fail_pend_d;
      pass_count_q <= pass_count_d;
      count_snap_q <= count_snap_d;
      state_snap_q <= state_snap_d;
      read_snap_q  <= read_snap_d;
      exp_snap_q   <= exp_snap_d;
    end
  end

  assign tx_valid   = (state_q != ST_IDLE);
  assign tx_data    = byte_sel;
  assign pass_count = pass_count_q;
  assign failed     = failed_q;

endmodule

// File: tb/tb_sram_test_reporter.sv
// Self-checking bench for sram_test_reporter: directed scenarios with random
// data/handshake, expected report lines built from a string-level model.
module tb_sram_test_reporter;

  localparam int DATA_BITS  = 16;
  localparam int COUNT_BITS = 16;

  localparam int RDY_ALWAYS = 0;
  localparam int RDY_TOGGLE = 1;
  localparam int RDY_RANDOM = 2;
  localparam int RDY_HOLD0  = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  test_done;
  logic                  test_pass;
  logic [2:0]            pattern_state;
  logic [DATA_BITS-1:0]  prev_read_data;
  logic [DATA_BITS-1:0]  prev_expected_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [COUNT_BITS-1:0] pass_count;
  logic                  failed;

  int tests = 0;
  int failures = 0;
  int rdy_mode = RDY_ALWAYS;
  int valid_cycles = 0;
  int model_count = 0;
  bit model_failed = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  sram_test_reporter #(
    .DATA_BITS  (DATA_BITS),
    .COUNT_BITS (COUNT_BITS)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .test_done          (test_done),
    .test_pass          (test_pass),
    .pattern_state      (pattern_state),
    .prev_read_data     (prev_read_data),
    .prev_expected_data (prev_expected_data),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .pass_count         (pass_count),
    .failed             (failed)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic string hex_str(input logic [31:0] v, input int ndig);
    string digits = "0123456789ABCDEF";
    string s = "";
    for (int i = ndig - 1; i >= 0; i--) begin
      int n = int'((v >> (4 * i)) & 32'hF);
      s = {s, digits.substr(n, n)};
    end
    return s;
  endfunction

  function automatic string pass_line(input int c);
    return {"P ", hex_str(c, COUNT_BITS / 4), "\r\n"};
  endfunction

  function automatic string fail_line(input int st, input int rd, input int ex);
    string d = "0";
    d.putc(0, byte'(8'h30 + st));
    return {"F ", d, " ", hex_str(rd, DATA_BITS / 4), " ", hex_str(ex, DATA_BITS / 4), "\r\n"};
  endfunction

  task automatic expectLine(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Byte collector plus handshake-hold and inter-message gap checks.
  initial begin
    bit stall_prev = 0;
    bit lf_prev = 0;
    logic [7:0] data_prev = 8'h00;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        stall_prev = 0;
        lf_prev = 0;
      end else begin
        if (stall_prev) begin
          checkOutput("hold_valid", {31'd0, tx_valid}, 32'd1);
          checkOutput("hold_data", {24'd0, tx_data}, {24'd0, data_prev});
        end
        if (lf_prev) checkOutput("gap", {31'd0, tx_valid}, 32'd0);
        lf_prev = 0;
        if (tx_valid) valid_cycles++;
        if (tx_valid && tx_ready) begin
          rx_q.push_back(tx_data);
          lf_prev = (tx_data == 8'h0A);
        end
        stall_prev = tx_valid && !tx_ready;
        data_prev = tx_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      RDY_ALWAYS: tx_ready = 1'b1;
      RDY_TOGGLE: tx_ready = ~tx_ready;
      RDY_RANDOM: tx_ready = 1'($urandom_range(0, 1));
      default:    tx_ready = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input logic done_v, input logic pass_v, input int cycles);
    test_done = done_v;
    test_pass = pass_v;
    repeat (cycles) tick();
  endtask

  task automatic passPulse();
    applyStimulus(1'b1, test_pass, 1);
    test_done = 1'b0;
    if (!model_failed) model_count = (model_count + 1) & ((1 << COUNT_BITS) - 1);
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    test_done = 1'b0;
    test_pass = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    model_count = 0;
    model_failed = 0;
  endtask

  task automatic compareRx(input string tag);
    int n;
    checkOutput({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic waitBytes(input string tag, input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    compareRx(tag);
    tick();
    tick();
    checkOutput({tag, "_idle"}, {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    int n_extra;
    int st, rd, ex;
    reset_n = 1'b0;
    test_done = 1'b0;
    test_pass = 1'b1;
    tx_ready = 1'b1;
    pattern_state = 3'd0;
    prev_read_data = '0;
    prev_expected_data = '0;

    // Reset state
    resetDut();
    checkOutput("rst_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_count", {16'd0, pass_count}, 32'd0);
    checkOutput("rst_failed", {31'd0, failed}, 32'd0);

    // Single pass, ready always high
    rdy_mode = RDY_ALWAYS;
    tx_ready = 1'b1;
    valid_cycles = 0;
    passPulse();
    checkOutput("t1_count", {16'd0, pass_count}, model_count);
    expectLine(pass_line(1));
    waitBytes("t1", 8, 100);
    checkOutput("t1_valid_cycles", valid_cycles, 32'd8);

    // Same pass with ready toggling
    resetDut();
    rdy_mode = RDY_TOGGLE;
    passPulse();
    expectLine(pass_line(1));
    waitBytes("t2", 8, 100);

    // Fail line; snapshot must survive later changes on the data inputs
    rx_q.delete();
    exp_q.delete();
    rdy_mode = RDY_RANDOM;
    pattern_state = 3'd3;
    prev_read_data = 16'h12AB;
    prev_expected_data = 16'h12AF;
    applyStimulus(1'b0, 1'b0, 1);
    model_failed = 1;
    checkOutput("t3_failed", {31'd0, failed}, 32'd1);
    pattern_state = 3'($urandom_range(0, 7));
    prev_read_data = 16'($urandom);
    prev_expected_data = 16'($urandom);
    expectLine(fail_line(3, 16'h12AB, 16'h12AF));
    waitBytes("t3", 15, 300);
    rx_q.delete();
    exp_q.delete();
    repeat (3) begin
      passPulse();
      tick();
    end
    repeat (20) tick();
    checkOutput("t3_no_bytes", rx_q.size(), 32'd0);
    checkOutput("t3_count_frozen", {16'd0, pass_count}, model_count);
    checkOutput("t3_still_failed", {31'd0, failed}, 32'd1);

    // Passes arriving during a stalled message coalesce into one line
    resetDut();
    rdy_mode = RDY_HOLD0;
    tx_ready = 1'b0;
    passPulse();
    tick();
    tick();
    n_extra = $urandom_range(2, 5);
    for (int i = 0; i < n_extra; i++) begin
      passPulse();
      tick();
    end
    checkOutput("co_count", {16'd0, pass_count}, model_count);
    expectLine(pass_line(1));
    expectLine(pass_line(model_count));
    rdy_mode = RDY_RANDOM;
    waitBytes("co", 16, 400);

    // Fail while byte 2 of a PASS line is stalled
    resetDut();
    rdy_mode = RDY_ALWAYS;
    passPulse();
    for (int i = 0; i < 50 && rx_q.size() < 2; i++) tick();
    rdy_mode = RDY_HOLD0;
    tx_ready = 1'b0;
    st = $urandom_range(0, 7);
    rd = int'(16'($urandom));
    ex = int'(16'($urandom));
    pattern_state = 3'(st);
    prev_read_data = 16'(rd);
    prev_expected_data = 16'(ex);
    applyStimulus(1'b0, 1'b0, 1);
    model_failed = 1;
    prev_read_data = ~prev_read_data;
    applyStimulus(1'b0, 1'b0, 3);
    expectLine(pass_line(1));
    expectLine(fail_line(st, rd, ex));
    rdy_mode = RDY_RANDOM;
    waitBytes("t4", 23, 500);

    // Counter wrap
    resetDut();
    rdy_mode = RDY_ALWAYS;
    force dut.pass_count_q = 16'hFFFF;
    tick();
    release dut.pass_count_q;
    model_count = 16'hFFFF;
    passPulse();
    checkOutput("t5_wrap", {16'd0, pass_count}, model_count);
    expectLine(pass_line(0));
    waitBytes("t5", 8, 100);

    // Reset in the middle of a FAIL line
    rx_q.delete();
    exp_q.delete();
    rdy_mode = RDY_RANDOM;
    pattern_state = 3'd5;
    prev_read_data = 16'($urandom);
    prev_expected_data = 16'($urandom);
    applyStimulus(1'b0, 1'b0, 1);
    for (int i = 0; i < 200 && rx_q.size() < 3; i++) tick();
    checkOutput("t6_pre_valid", {31'd0, tx_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_valid_drop", {31'd0, tx_valid}, 32'd0);
    checkOutput("t6_data_zero", {24'd0, tx_data}, 32'd0);
    checkOutput("t6_failed_clr", {31'd0, failed}, 32'd0);
    checkOutput("t6_count_clr", {16'd0, pass_count}, 32'd0);
    test_pass = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    model_count = 0;
    model_failed = 0;
    rdy_mode = RDY_ALWAYS;
    passPulse();
    expectLine(pass_line(1));
    waitBytes("t6", 8, 100);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
